receive: RTL and testbench
==========================

RECEIVE -- requirements
Module: receive

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  input  1  rising-edge clock; one line bit per cycle.
- rst  input  1  synchronous active-high reset.
- connection_status  input  1  link enable; low discards any partial frame.
- rxd  input  1  serial line; idle high; driven directly by the transmitter's txd.
- word_ready  input  1  consumer accepts word this cycle when word_valid=1.
- word  output  8  received byte; stable while word_valid=1.
- word_valid  output  1  word holds an unconsumed byte.
- frame_error  output  1  one-cycle pulse: trailer bit sampled as 1.
- overrun  output  1  sticky: a completed byte was dropped because the holding register was full.
- rx_busy  output  1  high in states DATA and TRAIL.

Function
REQ-002 Frame format SHALL be 10 consecutive clk cycles: start bit (0), data bits d0..d7 (LSB first), trailer bit (0); frames MAY be back-to-back with no idle-high gap.
REQ-003 The FSM SHALL have states IDLE, DATA and TRAIL; the reset state SHALL be IDLE.
REQ-004 IDLE: when connection_status=1 and rxd=0, the FSM SHALL consume that cycle as the start bit, clear the bit counter and go to DATA; rxd=1 SHALL keep it in IDLE.
REQ-005 DATA: each cycle the FSM SHALL shift rxd into bit position [counter], increment the 3-bit counter, and go to TRAIL after the 8th bit (counter wraps 7->0).
REQ-006 TRAIL, rxd=0: the FSM SHALL deliver the byte and return to IDLE, so that the next cycle's 0 is accepted as a new start bit.
REQ-007 TRAIL, rxd=1: the FSM SHALL pulse frame_error for exactly one cycle (the cycle after TRAIL), discard the byte, and return to IDLE.
REQ-008 Delivery latency SHALL be one cycle: word and word_valid update on the clk edge that ends the TRAIL cycle.
REQ-009 Handshake: a byte SHALL be consumed on a cycle where word_valid=1 and word_ready=1; word_valid then falls next cycle unless a new byte is delivered on the same edge.
REQ-010 Delivery and consumption on the same edge SHALL load the new byte with word_valid=1 and SHALL NOT set overrun.
REQ-011 Delivery while word_valid=1 and word_ready=0 SHALL keep the old word, drop the new byte and set overrun; overrun clears only on rst.
REQ-012 connection_status=0 SHALL force the FSM to IDLE within the same cycle and clear the counter and shift register; word, word_valid and overrun SHALL be unaffected.
REQ-013 The block SHALL emit no byte for a frame truncated by connection_status=0 or rst.

Reset
REQ-014 On rst=1 at a clk edge the block SHALL set: state IDLE, counter 0, shift register 0, word 8'h00, word_valid 0, frame_error 0, overrun 0, rx_busy 0.
REQ-015 rst SHALL take priority over connection_status, rxd and word_ready; rst in mid-frame SHALL abandon the frame.

Structure
REQ-016 A shared package uart_pkg SHALL hold DATA_BITS=8, FRAME_LEN=10, START_BIT=1'b0, TRAIL_BIT=1'b0 and the rx state encoding, so the transmitter and receiver share the frame definition.
REQ-017 The shift register and bit counter SHALL be one sub-module, rx_shifter (inputs: clk, rst, clear, shift_en, bit_in; outputs: data[7:0], last_bit); the FSM, holding register and flags SHALL be in receive.
REQ-018 All outputs SHALL be registered.

Verification
REQ-019 Byte 8'hA5, connection_status=1, word_ready=1: rxd = 0,1,0,1,0,0,1,0,1,0 -> word=8'hA5, word_valid=1 for exactly one cycle, one cycle after the trailer.
REQ-020 Back-to-back bytes 8'h3C then 8'hFF with no gap, word_ready=1 -> two valid pulses 10 cycles apart carrying 8'h3C then 8'hFF; frame_error=0 throughout.
REQ-021 Byte 8'h81 with the trailer forced to 1 -> frame_error pulses once, word_valid stays 0, the FSM is in IDLE the next cycle.
REQ-022 word_ready=0, bytes 8'h11 then 8'h22 -> word stays 8'h11, overrun=1; then word_ready=1 for one cycle -> word_valid=0 and overrun stays 1.
REQ-023 connection_status dropped after 4 data bits, then a full 8'h5A frame -> only 8'h5A is delivered.
REQ-024 rst asserted in cycle 6 of a frame -> all outputs reach their reset values next cycle, and a following 8'hC3 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Frame definition and rx state encoding shared by the UART transmitter and receiver.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned FRAME_LEN = 10;
  localparam int unsigned CNT_W     = $clog2(DATA_BITS);

  localparam logic START_BIT = 1'b0;
  localparam logic TRAIL_BIT = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    TRAIL = 2'd2
  } rx_state_t;

endpackage

// File: rtl/rx_shifter.sv
// LSB-first serial-to-parallel shift register with its own bit counter.
module rx_shifter
  import uart_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 shift_en,
  input  logic                 bit_in,
  output logic [DATA_BITS-1:0] data,
  output logic                 last_bit
);

  logic [CNT_W-1:0] cnt;

  // Each shifted bit lands at the position named by the counter; the counter wraps after the last bit.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      data <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      data[cnt] <= bit_in;
      cnt       <= cnt + CNT_W'(1);
    end
  end

  assign last_bit = (cnt == CNT_W'(DATA_BITS - 1));

endmodule

// File: rtl/receive.sv
// UART-style receiver: frame FSM, one-entry holding register with ready/valid handshake,
// frame error pulse and sticky overrun flag.
module receive
  import uart_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 connection_status,
  input  logic                 rxd,
  input  logic                 word_ready,
  output logic [DATA_BITS-1:0] word,
  output logic                 word_valid,
  output logic                 frame_error,
  output logic                 overrun,
  output logic                 rx_busy
);

  rx_state_t            state_q;
  rx_state_t            state_d;
  logic                 clear_sh;
  logic                 shift_en;
  logic                 deliver;
  logic                 ferr_set;
  logic [DATA_BITS-1:0] sh_data;
  logic                 sh_last;
  logic                 consume;

  rx_shifter u_shifter (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_sh),
    .shift_en (shift_en),
    .bit_in   (rxd),
    .data     (sh_data),
    .last_bit (sh_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; a dropped link returns to IDLE regardless of the current state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rxd == START_BIT) state_d = DATA;
      DATA:    if (sh_last)          state_d = TRAIL;
      TRAIL:                         state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
    if (!connection_status) state_d = IDLE;
  end

  always_comb begin
    clear_sh = 1'b0;
    shift_en = 1'b0;
    deliver  = 1'b0;
    ferr_set = 1'b0;
    if (!connection_status) begin
      clear_sh = 1'b1;
    end else begin
      case (state_q)
        IDLE:  clear_sh = (rxd == START_BIT);
        DATA:  shift_en = 1'b1;
        TRAIL: begin
          deliver  = (rxd == TRAIL_BIT);
          ferr_set = (rxd != TRAIL_BIT);
        end
        default: clear_sh = 1'b1;
      endcase
    end
  end

  assign consume = word_valid & word_ready;

  // Holding register: a delivery is accepted if the slot is empty or being drained on this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      word        <= '0;
      word_valid  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      frame_error <= ferr_set;
      rx_busy     <= (state_d != IDLE);
      if (deliver) begin
        if (!word_valid || word_ready) begin
          word       <= sh_data;
          word_valid <= 1'b1;
        end else begin
          overrun    <= 1'b1;
        end
      end else if (consume) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_receive.sv
// Directed self-checking bench for the receive block.
module tb_receive;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       connection_status;
  logic       rxd;
  logic       word_ready;
  logic [7:0] word;
  logic       word_valid;
  logic       frame_error;
  logic       overrun;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;

  receive dut (
    .clk               (clk),
    .rst               (rst),
    .connection_status (connection_status),
    .rxd               (rxd),
    .word_ready        (word_ready),
    .word              (word),
    .word_valid        (word_valid),
    .frame_error       (frame_error),
    .overrun           (overrun),
    .rx_busy           (rx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one full frame; returns #1 after the edge that ends the trailer cycle.
  task automatic send_frame(input logic [7:0] b, input logic trail, input logic ready_at_trail);
    rxd = START_BIT;
    tick();
    for (int i = 0; i < DATA_BITS; i++) begin
      rxd = b[i];
      tick();
    end
    rxd = trail;
    if (ready_at_trail) word_ready = 1'b1;
    tick();
    rxd = 1'b1;
  endtask

  task automatic idle_cycle();
    rxd = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    connection_status = 1'b1;
    rxd = 1'b1;
    word_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check("rst_word", 32'(word), 32'h00);
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_ferr", 32'(frame_error), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);

    // Idle line stays idle
    idle_cycle();
    check("idle_busy", 32'(rx_busy), 32'd0);

    // Single byte A5
    rxd = 1'b0;
    tick();
    check("a5_busy_after_start", 32'(rx_busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      rxd = (8'hA5 >> i) & 8'h01 ? 1'b1 : 1'b0;
      tick();
    end
    check("a5_valid_before_trail", 32'(word_valid), 32'd0);
    rxd = 1'b0;
    tick();
    rxd = 1'b1;
    check("a5_valid", 32'(word_valid), 32'd1);
    check("a5_word", 32'(word), 32'hA5);
    check("a5_busy_end", 32'(rx_busy), 32'd0);
    idle_cycle();
    check("a5_valid_one_cycle", 32'(word_valid), 32'd0);

    // Back-to-back 3C then FF
    send_frame(8'h3C, 1'b0, 1'b0);
    check("b2b_valid1", 32'(word_valid), 32'd1);
    check("b2b_word1", 32'(word), 32'h3C);
    check("b2b_ferr1", 32'(frame_error), 32'd0);
    send_frame(8'hFF, 1'b0, 1'b0);
    check("b2b_valid2", 32'(word_valid), 32'd1);
    check("b2b_word2", 32'(word), 32'hFF);
    check("b2b_ferr2", 32'(frame_error), 32'd0);

    // 81 with bad trailer
    send_frame(8'h81, 1'b1, 1'b0);
    check("fe_pulse", 32'(frame_error), 32'd1);
    check("fe_valid", 32'(word_valid), 32'd0);
    check("fe_idle", 32'(rx_busy), 32'd0);
    check("fe_word_kept", 32'(word), 32'hFF);
    idle_cycle();
    check("fe_one_cycle", 32'(frame_error), 32'd0);

    // Delivery and consumption on the same edge
    word_ready = 1'b0;
    send_frame(8'h44, 1'b0, 1'b0);
    check("same_valid_44", 32'(word_valid), 32'd1);
    send_frame(8'h55, 1'b0, 1'b1);
    check("same_word", 32'(word), 32'h55);
    check("same_valid", 32'(word_valid), 32'd1);
    check("same_overrun", 32'(overrun), 32'd0);
    idle_cycle();
    check("same_drain", 32'(word_valid), 32'd0);

    // Overrun: 11 held, 22 dropped
    word_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0);
    check("ovr_word1", 32'(word), 32'h11);
    check("ovr_flag_pre", 32'(overrun), 32'd0);
    send_frame(8'h22, 1'b0, 1'b0);
    check("ovr_word_kept", 32'(word), 32'h11);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_valid", 32'(word_valid), 32'd1);
    word_ready = 1'b1;
    idle_cycle();
    check("ovr_drain_valid", 32'(word_valid), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Link drop after 4 data bits, then 5A
    rxd = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      rxd = 1'b0;
      tick();
    end
    connection_status = 1'b0;
    rxd = 1'b0;
    tick();
    check("drop_busy", 32'(rx_busy), 32'd0);
    tick();
    check("drop_busy_held", 32'(rx_busy), 32'd0);
    connection_status = 1'b1;
    rxd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("drop_no_valid", 32'(word_valid), 32'd0);
    end
    check("drop_word_kept", 32'(word), 32'h11);
    check("drop_overrun_kept", 32'(overrun), 32'd1);
    word_ready = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0);
    check("drop_word", 32'(word), 32'h5A);
    check("drop_valid", 32'(word_valid), 32'd1);

    // rst in cycle 6 of a frame while word_valid and overrun are set
    rxd = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      rxd = ((8'hC3 >> i) & 8'h01) ? 1'b1 : 1'b0;
      tick();
    end
    rst = 1'b1;
    rxd = 1'b0;
    tick();
    rst = 1'b0;
    rxd = 1'b1;
    check("mrst_word", 32'(word), 32'h00);
    check("mrst_valid", 32'(word_valid), 32'd0);
    check("mrst_ferr", 32'(frame_error), 32'd0);
    check("mrst_overrun", 32'(overrun), 32'd0);
    check("mrst_busy", 32'(rx_busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mrst_no_valid", 32'(word_valid), 32'd0);
    end
    word_ready = 1'b1;
    send_frame(8'hC3, 1'b0, 1'b0);
    check("mrst_c3_word", 32'(word), 32'hC3);
    check("mrst_c3_valid", 32'(word_valid), 32'd1);
    check("mrst_c3_ferr", 32'(frame_error), 32'd0);
    idle_cycle();
    check("mrst_c3_drain", 32'(word_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
